// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared constants and state encoding for the ALU command sequencer
package alu_ctrl_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    localparam logic [1:0] CLS_ARITH = 2'b00;
    localparam logic [1:0] CLS_LOGIC = 2'b01;
    localparam logic [1:0] CLS_CMP   = 2'b10;
    localparam logic [1:0] CLS_SHIFT = 2'b11;

    // Plain encoded constants keep the state register compatible with legacy tooling.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_GATE    = 3'd1;
    localparam state_t ST_EXEC    = 3'd2;
    localparam state_t ST_WAIT    = 3'd3;
    localparam state_t ST_SEND_LO = 3'd4;
    localparam state_t ST_SEND_HI = 3'd5;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// rtl/alu_cmd_sequencer_if.sv - command, ALU and TX byte signals of the ALU command sequencer
interface alu_cmd_sequencer_if
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();

    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [3:0]                cmd_fun;
    logic [DATA_WIDTH-1:0]     cmd_a;
    logic [DATA_WIDTH-1:0]     cmd_b;
    logic                      alu_clk_en;
    logic                      alu_en;
    logic [3:0]                alu_fun;
    logic [DATA_WIDTH-1:0]     alu_a;
    logic [DATA_WIDTH-1:0]     alu_b;
    logic [2*DATA_WIDTH-1:0]   alu_out;
    logic                      alu_out_valid;
    logic [DATA_WIDTH-1:0]     tx_data;
    logic                      tx_valid;
    logic                      tx_ready;
    logic                      busy;
    logic                      err_timeout;

    modport master (
        input  cmd_valid, cmd_fun, cmd_a, cmd_b, alu_out, alu_out_valid, tx_ready,
        output cmd_ready, alu_clk_en, alu_en, alu_fun, alu_a, alu_b,
               tx_data, tx_valid, busy, err_timeout
    );

    modport slave (
        output cmd_valid, cmd_fun, cmd_a, cmd_b, alu_out, alu_out_valid, tx_ready,
        input  cmd_ready, alu_clk_en, alu_en, alu_fun, alu_a, alu_b,
               tx_data, tx_valid, busy, err_timeout
    );

endinterface

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - runs one ALU operation per command and streams the result out as bytes
module alu_cmd_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int TIMEOUT    = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    alu_cmd_sequencer_if.master  bus
);

    localparam int                CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t                    state;
    state_t                    next_state;
    logic [3:0]                fun_q;
    logic [DATA_WIDTH-1:0]     a_q;
    logic [DATA_WIDTH-1:0]     b_q;
    logic [2*DATA_WIDTH-1:0]   result;
    logic [CNT_W-1:0]          cnt;
    logic                      err_q;
    logic                      timed_out;

    // A result arriving on the last counted cycle takes priority over the abort.
    assign timed_out = (state == ST_WAIT) && !bus.alu_out_valid && (cnt == CNT_LAST);

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (bus.cmd_valid) next_state = ST_GATE;
            ST_GATE:    next_state = ST_EXEC;
            ST_EXEC:    next_state = ST_WAIT;
            ST_WAIT: begin
                if (bus.alu_out_valid)    next_state = ST_SEND_LO;
                else if (cnt == CNT_LAST) next_state = ST_IDLE;
            end
            ST_SEND_LO: if (bus.tx_ready)
                            next_state = (fun_q[3:2] == CLS_ARITH) ? ST_SEND_HI : ST_IDLE;
            ST_SEND_HI: if (bus.tx_ready) next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= ST_IDLE;
            fun_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            result <= '0;
            cnt    <= '0;
            err_q  <= 1'b0;
        end else begin
            state <= next_state;
            err_q <= timed_out;
            if (state == ST_IDLE && bus.cmd_valid) begin
                fun_q <= bus.cmd_fun;
                a_q   <= bus.cmd_a;
                b_q   <= bus.cmd_b;
            end
            if (state == ST_EXEC)
                cnt <= '0;
            else if (state == ST_WAIT && cnt != CNT_LAST)
                cnt <= cnt + 1'b1;
            if (state == ST_WAIT && bus.alu_out_valid)
                result <= bus.alu_out;
        end
    end

    // Ready is masked by reset so the source never sees a handshake while held in reset.
    assign bus.cmd_ready   = (state == ST_IDLE) && !RST;
    assign bus.busy        = (state != ST_IDLE);
    assign bus.alu_clk_en  = (state == ST_GATE) || (state == ST_EXEC) || (state == ST_WAIT);
    assign bus.alu_en      = (state == ST_EXEC);
    assign bus.alu_fun     = fun_q;
    assign bus.alu_a       = a_q;
    assign bus.alu_b       = b_q;
    assign bus.tx_valid    = (state == ST_SEND_LO) || (state == ST_SEND_HI);
    assign bus.err_timeout = err_q;

    always_comb begin
        bus.tx_data = '0;
        if (state == ST_SEND_LO)
            bus.tx_data = result[DATA_WIDTH-1:0];
        else if (state == ST_SEND_HI)
            bus.tx_data = result[2*DATA_WIDTH-1:DATA_WIDTH];
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - directed self-checking bench for alu_cmd_sequencer
module tb_alu_cmd_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    alu_cmd_sequencer_if #(.DATA_WIDTH(8)) bus ();

    alu_cmd_sequencer #(.DATA_WIDTH(8), .TIMEOUT(8)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents a command in IDLE; returns one cycle later in GATE with cmd_valid dropped.
    task automatic send_cmd(input logic [3:0] fun, input logic [7:0] a, input logic [7:0] b);
        bus.cmd_fun   = fun;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_valid = 1'b1;
        chk("accept_ready", {31'd0, bus.cmd_ready}, 32'd1);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        bus.cmd_valid     = 1'b0;
        bus.cmd_fun       = 4'h0;
        bus.cmd_a         = 8'h00;
        bus.cmd_b         = 8'h00;
        bus.alu_out       = 16'h0000;
        bus.alu_out_valid = 1'b0;
        bus.tx_ready      = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
        chk("rst_busy",      {31'd0, bus.busy}, 32'd0);
        chk("rst_clk_en",    {31'd0, bus.alu_clk_en}, 32'd0);
        chk("rst_alu_en",    {31'd0, bus.alu_en}, 32'd0);
        chk("rst_alu_fun",   {28'd0, bus.alu_fun}, 32'd0);
        chk("rst_alu_a",     {24'd0, bus.alu_a}, 32'd0);
        chk("rst_alu_b",     {24'd0, bus.alu_b}, 32'd0);
        chk("rst_tx_valid",  {31'd0, bus.tx_valid}, 32'd0);
        chk("rst_tx_data",   {24'd0, bus.tx_data}, 32'd0);
        chk("rst_err",       {31'd0, bus.err_timeout}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {31'd0, bus.cmd_ready}, 32'd1);

        // Arith add: F0 + 20 = 0110, two bytes out
        send_cmd(4'b0000, 8'hF0, 8'h20);
        chk("ar_c1_clk_en", {31'd0, bus.alu_clk_en}, 32'd1);
        chk("ar_c1_alu_en", {31'd0, bus.alu_en}, 32'd0);
        chk("ar_c1_alu_a",  {24'd0, bus.alu_a}, 32'h0F0);
        chk("ar_c1_alu_b",  {24'd0, bus.alu_b}, 32'h020);
        chk("ar_c1_ready",  {31'd0, bus.cmd_ready}, 32'd0);
        chk("ar_c1_busy",   {31'd0, bus.busy}, 32'd1);
        tick();
        chk("ar_c2_alu_en", {31'd0, bus.alu_en}, 32'd1);
        chk("ar_c2_clk_en", {31'd0, bus.alu_clk_en}, 32'd1);
        tick();
        chk("ar_c3_alu_en", {31'd0, bus.alu_en}, 32'd0);
        chk("ar_c3_clk_en", {31'd0, bus.alu_clk_en}, 32'd1);
        chk("ar_c3_txv",    {31'd0, bus.tx_valid}, 32'd0);
        bus.alu_out       = 16'h0110;
        bus.alu_out_valid = 1'b1;
        tick();
        // A stray result outside WAIT must not overwrite the captured one.
        bus.alu_out       = 16'hBEEF;
        chk("ar_c4_txv",    {31'd0, bus.tx_valid}, 32'd1);
        chk("ar_c4_lo",     {24'd0, bus.tx_data}, 32'h10);
        chk("ar_c4_clk_en", {31'd0, bus.alu_clk_en}, 32'd0);
        chk("ar_c4_alu_en", {31'd0, bus.alu_en}, 32'd0);
        tick();
        bus.alu_out_valid = 1'b0;
        chk("ar_c5_txv",    {31'd0, bus.tx_valid}, 32'd1);
        chk("ar_c5_hi",     {24'd0, bus.tx_data}, 32'h01);
        chk("ar_c5_busy",   {31'd0, bus.busy}, 32'd1);
        tick();
        chk("ar_c6_txv",    {31'd0, bus.tx_valid}, 32'd0);
        chk("ar_c6_busy",   {31'd0, bus.busy}, 32'd0);
        chk("ar_c6_ready",  {31'd0, bus.cmd_ready}, 32'd1);

        // Logic class: single byte A5, ready again in cycle 5
        send_cmd(4'b0100, 8'h5A, 8'hFF);
        tick();
        tick();
        bus.alu_out       = 16'h00A5;
        bus.alu_out_valid = 1'b1;
        tick();
        bus.alu_out_valid = 1'b0;
        chk("lg_c4_txv",    {31'd0, bus.tx_valid}, 32'd1);
        chk("lg_c4_data",   {24'd0, bus.tx_data}, 32'hA5);
        chk("lg_c4_clk_en", {31'd0, bus.alu_clk_en}, 32'd0);
        chk("lg_c4_ready",  {31'd0, bus.cmd_ready}, 32'd0);
        tick();
        chk("lg_c5_txv",    {31'd0, bus.tx_valid}, 32'd0);
        chk("lg_c5_clk_en", {31'd0, bus.alu_clk_en}, 32'd0);
        chk("lg_c5_ready",  {31'd0, bus.cmd_ready}, 32'd1);
        chk("lg_c5_busy",   {31'd0, bus.busy}, 32'd0);

        // Backpressure in SEND_LO with an ignored command pulse
        send_cmd(4'b0000, 8'hF0, 8'h20);
        tick();
        tick();
        bus.alu_out       = 16'h0110;
        bus.alu_out_valid = 1'b1;
        bus.tx_ready      = 1'b0;
        tick();
        bus.alu_out_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_txv",   {31'd0, bus.tx_valid}, 32'd1);
            chk("bp_data",  {24'd0, bus.tx_data}, 32'h10);
            chk("bp_ready", {31'd0, bus.cmd_ready}, 32'd0);
            bus.cmd_valid = (i == 2);
            bus.cmd_fun   = 4'b1100;
            bus.cmd_a     = 8'h33;
            tick();
        end
        bus.cmd_valid = 1'b0;
        bus.tx_ready  = 1'b1;
        chk("bp_lo_held", {24'd0, bus.tx_data}, 32'h10);
        tick();
        chk("bp_hi",      {24'd0, bus.tx_data}, 32'h01);
        tick();
        chk("bp_idle",    {31'd0, bus.busy}, 32'd0);
        chk("bp_fun_kept", {28'd0, bus.alu_fun}, 32'd0);
        chk("bp_a_kept",  {24'd0, bus.alu_a}, 32'hF0);

        // Timeout: no result, abort after eight WAIT cycles
        send_cmd(4'b1000, 8'h11, 8'h22);
        tick();
        for (int c = 3; c <= 10; c++) begin
            tick();
            chk("to_wait_err", {31'd0, bus.err_timeout}, 32'd0);
            chk("to_wait_txv", {31'd0, bus.tx_valid}, 32'd0);
            chk("to_wait_clk", {31'd0, bus.alu_clk_en}, 32'd1);
        end
        tick();
        chk("to_err_pulse", {31'd0, bus.err_timeout}, 32'd1);
        chk("to_txv",       {31'd0, bus.tx_valid}, 32'd0);
        chk("to_busy",      {31'd0, bus.busy}, 32'd0);
        chk("to_ready",     {31'd0, bus.cmd_ready}, 32'd1);
        tick();
        chk("to_err_once",  {31'd0, bus.err_timeout}, 32'd0);
        chk("to_txv2",      {31'd0, bus.tx_valid}, 32'd0);

        // Race: result on the last counted cycle wins over the abort
        send_cmd(4'b1101, 8'h2D, 8'h01);
        tick();
        for (int c = 3; c <= 10; c++) begin
            tick();
            if (c == 10) begin
                bus.alu_out       = 16'h005A;
                bus.alu_out_valid = 1'b1;
            end
        end
        tick();
        bus.alu_out_valid = 1'b0;
        chk("race_err",  {31'd0, bus.err_timeout}, 32'd0);
        chk("race_txv",  {31'd0, bus.tx_valid}, 32'd1);
        chk("race_data", {24'd0, bus.tx_data}, 32'h5A);
        tick();
        chk("race_err2", {31'd0, bus.err_timeout}, 32'd0);
        chk("race_idle", {31'd0, bus.busy}, 32'd0);

        // Reset while holding the low byte of an arith result
        send_cmd(4'b0011, 8'h12, 8'h34);
        tick();
        tick();
        bus.alu_out       = 16'h0110;
        bus.alu_out_valid = 1'b1;
        bus.tx_ready      = 1'b0;
        tick();
        bus.alu_out_valid = 1'b0;
        chk("mr_lo_txv", {31'd0, bus.tx_valid}, 32'd1);
        rst = 1'b1;
        tick();
        chk("mr_busy",   {31'd0, bus.busy}, 32'd0);
        chk("mr_txv",    {31'd0, bus.tx_valid}, 32'd0);
        chk("mr_txd",    {24'd0, bus.tx_data}, 32'd0);
        chk("mr_fun",    {28'd0, bus.alu_fun}, 32'd0);
        chk("mr_a",      {24'd0, bus.alu_a}, 32'd0);
        chk("mr_b",      {24'd0, bus.alu_b}, 32'd0);
        chk("mr_clk_en", {31'd0, bus.alu_clk_en}, 32'd0);
        chk("mr_ready",  {31'd0, bus.cmd_ready}, 32'd0);
        rst = 1'b0;
        bus.tx_ready = 1'b1;
        #1;
        chk("mr_ready_up", {31'd0, bus.cmd_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mr_no_hi", {31'd0, bus.tx_valid}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
